// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA pixel feeder
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic    sof;
        logic    eol;
        rgb444_t rgb;
    } pix_word_t;

    typedef enum logic [1:0] {
        SEEK,
        ARMED,
        RUN,
        FLUSH
    } feeder_state_t;

endpackage

// File: rtl/pix_sync_fifo.sv
// rtl/pix_sync_fifo.sv - single-clock FIFO, head word read from a register-addressed array
module pix_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Full blocks writes even when a pop happens in the same cycle.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pix_feeder.sv
// rtl/vga_pix_feeder.sv - frame-locked pixel source feeding the VGA timing generator
module vga_pix_feeder
    import vga_pkg::*;
#(
    parameter int      DEPTH      = 1024,
    parameter int      H_ACTIVE   = H_ACTIVE_DEF,
    parameter int      V_ACTIVE   = V_ACTIVE_DEF,
    parameter rgb444_t FILL_COLOR = 12'h000
) (
    input  logic                     pix_clk,
    input  logic                     rst,
    input  logic [11:0]              s_pix_tdata,
    input  logic                     s_pix_tvalid,
    output logic                     s_pix_tready,
    input  logic                     s_pix_tuser,
    input  logic                     s_pix_tlast,
    input  logic                     frame_start,
    input  logic                     pix_en,
    output logic [11:0]              pix_rgb,
    output logic                     locked,
    output logic                     underflow,
    output logic                     sync_err,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] V_LAST = RW'(V_ACTIVE - 1);

    feeder_state_t r_state;
    feeder_state_t w_state_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    rgb444_t       r_pix_rgb;
    logic          r_underflow;
    logic          r_sync_err;

    logic          w_tready;
    logic          w_wr_en;
    logic          w_pop;
    logic          w_flush;
    logic          w_uf_set;
    logic          w_se_set;
    rgb444_t       w_rgb_next;
    logic          w_full;
    logic          w_empty;
    logic [13:0]   w_rd_data;
    pix_word_t     w_head;
    pix_word_t     w_wr_word;
    logic          w_at_origin;
    logic          w_at_eol;

    assign w_head      = pix_word_t'(w_rd_data);
    assign w_wr_word   = '{sof: s_pix_tuser, eol: s_pix_tlast, rgb: s_pix_tdata};
    assign w_at_origin = (r_col == '0) && (r_row == '0);
    assign w_at_eol    = (r_col == H_LAST);

    pix_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pix_word_t))
    ) u_fifo (
        .clk       (pix_clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    always_comb begin
        w_state_next = r_state;
        w_tready     = 1'b0;
        w_wr_en      = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_uf_set     = 1'b0;
        w_se_set     = 1'b0;
        w_rgb_next   = FILL_COLOR;
        case (r_state)
            SEEK: begin
                // Everything is accepted; only an SOF beat is kept.
                w_tready = 1'b1;
                if (s_pix_tvalid && s_pix_tuser && !w_full) begin
                    w_wr_en      = 1'b1;
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                w_tready = !w_full;
                w_wr_en  = s_pix_tvalid && !w_full;
                if (frame_start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_tready = !w_full;
                w_wr_en  = s_pix_tvalid && !w_full;
                // frame_start has priority over a coincident pix_en.
                if (frame_start && !w_at_origin) begin
                    w_se_set     = 1'b1;
                    w_state_next = FLUSH;
                end else if (pix_en) begin
                    if (w_empty) begin
                        w_uf_set     = 1'b1;
                        w_state_next = FLUSH;
                    end else begin
                        w_pop      = 1'b1;
                        w_rgb_next = w_head.rgb;
                        if ((w_head.sof != w_at_origin) || (w_head.eol != w_at_eol)) begin
                            w_se_set     = 1'b1;
                            w_state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                w_flush      = 1'b1;
                w_state_next = SEEK;
            end
            default: begin
                w_state_next = SEEK;
            end
        endcase
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEEK;
            r_col       <= '0;
            r_row       <= '0;
            r_pix_rgb   <= '0;
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pix_rgb <= w_rgb_next;
            if ((r_state == ARMED && frame_start) || r_state == FLUSH) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_pop) begin
                if (w_at_eol) begin
                    r_col <= '0;
                    r_row <= (r_row == V_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
            if (w_se_set) begin
                r_sync_err <= 1'b1;
            end else if (err_clr) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    assign s_pix_tready = w_tready && !rst;
    assign locked       = (r_state == RUN);
    assign pix_rgb      = r_pix_rgb;
    assign underflow    = r_underflow;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_vga_pix_feeder.sv
// tb/tb_vga_pix_feeder.sv - directed vector bench for vga_pix_feeder (4x2 frame, depth 16)
module tb_vga_pix_feeder;

    localparam logic [11:0] F = 12'hE5A;

    logic        pix_clk;
    logic        rst;
    logic [11:0] s_pix_tdata;
    logic        s_pix_tvalid;
    logic        s_pix_tready;
    logic        s_pix_tuser;
    logic        s_pix_tlast;
    logic        frame_start;
    logic        pix_en;
    logic [11:0] pix_rgb;
    logic        locked;
    logic        underflow;
    logic        sync_err;
    logic        err_clr;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        vld;
        logic [11:0] dat;
        logic        usr;
        logic        lst;
        logic        fs;
        logic        pen;
        logic        clr;
        logic [11:0] e_rgb;
        logic        e_lck;
        logic        e_uf;
        logic        e_se;
        int          e_lvl;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    vga_pix_feeder #(
        .DEPTH      (16),
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .FILL_COLOR (F)
    ) dut (
        .pix_clk      (pix_clk),
        .rst          (rst),
        .s_pix_tdata  (s_pix_tdata),
        .s_pix_tvalid (s_pix_tvalid),
        .s_pix_tready (s_pix_tready),
        .s_pix_tuser  (s_pix_tuser),
        .s_pix_tlast  (s_pix_tlast),
        .frame_start  (frame_start),
        .pix_en       (pix_en),
        .pix_rgb      (pix_rgb),
        .locked       (locked),
        .underflow    (underflow),
        .sync_err     (sync_err),
        .err_clr      (err_clr),
        .level        (level)
    );

    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic vec(input string nm, input logic vld, input logic [11:0] d,
                       input logic u, input logic l, input logic fs, input logic pen,
                       input logic clr, input logic [11:0] e_rgb, input logic e_lck,
                       input logic e_uf, input logic e_se, input int e_lvl, input logic e_rdy);
        vec_t v;
        v = '{name: nm, vld: vld, dat: d, usr: u, lst: l, fs: fs, pen: pen, clr: clr,
              e_rgb: e_rgb, e_lck: e_lck, e_uf: e_uf, e_se: e_se, e_lvl: e_lvl, e_rdy: e_rdy};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic [11:0] d, input logic u,
                         input logic l, input logic fs, input logic pen, input logic clr);
        s_pix_tvalid = vld;
        s_pix_tdata  = d;
        s_pix_tuser  = u;
        s_pix_tlast  = l;
        frame_start  = fs;
        pix_en       = pen;
        err_clr      = clr;
    endtask

    task automatic step();
        @(posedge pix_clk);
        @(negedge pix_clk);
    endtask

    function automatic logic [11:0] bp_dat(input int k);
        return 12'h100 + 12'(k);
    endfunction

    initial begin
        int acc;
        logic rdy_s;

        rst = 1'b1;
        drive(0, 12'h0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_rgb", pix_rgb, 12'h000);
        chk("rst_locked", locked, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_level", level, 0);
        chk("rst_tready", s_pix_tready, 0);
        rst = 1'b0;

        // Junk without SOF, then a valid frame, ARMED fill, lock and drain.
        vec("junk", 1, 12'hAAA, 0, 0, 0, 0, 0, F, 0, 0, 0, 0, 1);
        vec("junk", 1, 12'hBBB, 0, 0, 0, 0, 0, F, 0, 0, 0, 0, 1);
        vec("junk", 1, 12'hCCC, 0, 1, 0, 0, 0, F, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            vec("push1", 1, 12'(k), k == 1, k % 4 == 0, 0, 0, 0, F, 0, 0, 0, k, 1);
        vec("armed_fill", 0, 0, 0, 0, 0, 1, 0, F, 0, 0, 0, 8, 1);
        vec("lock_fs", 0, 0, 0, 0, 1, 0, 0, F, 1, 0, 0, 8, 1);
        for (int k = 1; k <= 8; k++)
            vec("pop1", 0, 0, 0, 0, 0, 1, 0, 12'(k), 1, 0, 0, 8 - k, 1);
        vec("idle1", 0, 0, 0, 0, 0, 0, 0, F, 1, 0, 0, 0, 1);

        // Underflow: only 5 of 8 pixels present.
        for (int k = 1; k <= 5; k++)
            vec("push_uf", 1, 12'h010 + 12'(k), k == 1, k == 4, 0, 0, 0, F, 1, 0, 0, k, 1);
        vec("uf_fs", 0, 0, 0, 0, 1, 0, 0, F, 1, 0, 0, 5, 1);
        for (int k = 1; k <= 5; k++)
            vec("pop_uf", 0, 0, 0, 0, 0, 1, 0, 12'h010 + 12'(k), 1, 0, 0, 5 - k, 1);
        vec("uf_hit", 0, 0, 0, 0, 0, 1, 0, F, 0, 1, 0, 0, 0);
        vec("uf_seek", 0, 0, 0, 0, 0, 1, 0, F, 0, 1, 0, 0, 1);
        vec("uf_seek2", 0, 0, 0, 0, 0, 1, 0, F, 0, 1, 0, 0, 1);

        // Relock after underflow, then clear the sticky flag.
        for (int k = 1; k <= 8; k++)
            vec("push2", 1, 12'h020 + 12'(k), k == 1, k % 4 == 0, 0, 0, 0, F, 0, 1, 0, k, 1);
        vec("relock_fs", 0, 0, 0, 0, 1, 0, 0, F, 1, 1, 0, 8, 1);
        for (int k = 1; k <= 8; k++)
            vec("pop2", 0, 0, 0, 0, 0, 1, 0, 12'h020 + 12'(k), 1, 1, 0, 8 - k, 1);
        vec("clr_uf", 0, 0, 0, 0, 0, 0, 1, F, 1, 0, 0, 0, 1);

        // Misaligned EOL on the 3rd pixel.
        for (int k = 1; k <= 8; k++)
            vec("push3", 1, 12'h030 + 12'(k), k == 1, k == 3 || k == 8, 0, 0, 0, F, 1, 0, 0, k, 1);
        vec("mis_fs", 0, 0, 0, 0, 1, 0, 0, F, 1, 0, 0, 8, 1);
        vec("pop3", 0, 0, 0, 0, 0, 1, 0, 12'h031, 1, 0, 0, 7, 1);
        vec("pop3", 0, 0, 0, 0, 0, 1, 0, 12'h032, 1, 0, 0, 6, 1);
        vec("mis_eol", 0, 0, 0, 0, 0, 1, 0, 12'h033, 0, 0, 1, 5, 0);
        vec("mis_flush", 0, 0, 0, 0, 0, 0, 0, F, 0, 0, 1, 0, 1);
        vec("clr_se", 0, 0, 0, 0, 0, 0, 1, F, 0, 0, 0, 0, 1);

        // frame_start arriving mid-frame.
        for (int k = 1; k <= 8; k++)
            vec("push4", 1, 12'h050 + 12'(k), k == 1, k % 4 == 0, 0, 0, 0, F, 0, 0, 0, k, 1);
        vec("fs4", 0, 0, 0, 0, 1, 0, 0, F, 1, 0, 0, 8, 1);
        vec("pop4", 0, 0, 0, 0, 0, 1, 0, 12'h051, 1, 0, 0, 7, 1);
        vec("pop4", 0, 0, 0, 0, 0, 1, 0, 12'h052, 1, 0, 0, 6, 1);
        vec("late_fs", 0, 0, 0, 0, 1, 0, 0, F, 0, 0, 1, 6, 0);
        vec("late_flush", 0, 0, 0, 0, 0, 0, 0, F, 0, 0, 1, 0, 1);
        vec("clr_se2", 0, 0, 0, 0, 0, 0, 1, F, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].dat, vecs[i].usr, vecs[i].lst,
                  vecs[i].fs, vecs[i].pen, vecs[i].clr);
            step();
            chk({vecs[i].name, "_rgb"}, pix_rgb, vecs[i].e_rgb);
            chk({vecs[i].name, "_locked"}, locked, vecs[i].e_lck);
            chk({vecs[i].name, "_underflow"}, underflow, vecs[i].e_uf);
            chk({vecs[i].name, "_sync_err"}, sync_err, vecs[i].e_se);
            chk({vecs[i].name, "_level"}, 32'(level), vecs[i].e_lvl);
            chk({vecs[i].name, "_tready"}, s_pix_tready, vecs[i].e_rdy);
        end
        drive(0, 12'h0, 0, 0, 0, 0, 0);

        // Backpressure: fill to 16, beat 16 must wait.
        acc = 0;
        for (int c = 0; c < 40 && acc < 16; c++) begin
            drive(1, bp_dat(acc), acc % 8 == 0, acc % 4 == 3, 0, 0, 0);
            rdy_s = s_pix_tready;
            step();
            if (rdy_s) acc++;
        end
        chk("bp_accepted", acc, 16);
        chk("bp_level_full", level, 16);
        chk("bp_tready_full", s_pix_tready, 0);
        drive(1, bp_dat(16), 1, 0, 0, 0, 0);
        step();
        chk("bp_level_hold", level, 16);
        chk("bp_tready_hold", s_pix_tready, 0);
        drive(0, 12'h0, 0, 0, 1, 0, 0);
        step();
        chk("bp_locked", locked, 1);
        for (int k = 0; k < 16; k++) begin
            drive(0, 12'h0, 0, 0, 0, 1, 0);
            step();
            chk($sformatf("bp_pop%0d", k), pix_rgb, bp_dat(k));
        end
        drive(0, 12'h0, 0, 0, 0, 0, 0);
        chk("bp_level_drained", level, 0);
        chk("bp_tready_back", s_pix_tready, 1);
        for (int k = 16; k < 20; k++) begin
            drive(1, bp_dat(k), k % 8 == 0, k % 4 == 3, 0, 0, 0);
            step();
        end
        chk("bp_level_rest", level, 4);
        for (int k = 16; k < 20; k++) begin
            drive(0, 12'h0, 0, 0, 0, 1, 0);
            step();
            chk($sformatf("bp_pop%0d", k), pix_rgb, bp_dat(k));
        end
        chk("bp_flags", {locked, underflow, sync_err}, 3'b100);

        // Async reset mid-frame (now at row 1, col 0).
        drive(1, 12'h200, 0, 0, 0, 0, 0);
        step();
        drive(1, 12'h201, 0, 0, 0, 0, 0);
        step();
        drive(0, 12'h0, 0, 0, 0, 1, 0);
        step();
        chk("mid_pop", pix_rgb, 12'h200);
        chk("mid_level", level, 1);
        drive(0, 12'h0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rgb", pix_rgb, 12'h000);
        chk("arst_locked", locked, 0);
        chk("arst_level", level, 0);
        chk("arst_tready", s_pix_tready, 0);
        step();
        rst = 1'b0;
        drive(1, 12'h300, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_discard", level, 0);
        chk("post_rst_rgb", pix_rgb, F);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 12'h300 + 12'(k), k == 1, k % 4 == 0, 0, 0, 0);
            step();
        end
        drive(0, 12'h0, 0, 0, 1, 0, 0);
        step();
        chk("post_rst_locked", locked, 1);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 12'h0, 0, 0, 0, 1, 0);
            step();
            chk($sformatf("post_rst_pop%0d", k), pix_rgb, 12'h300 + 12'(k));
        end
        drive(0, 12'h0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_flags", {locked, underflow, sync_err, level}, {3'b100, 5'd0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
